// File: rtl/ok_stim_checker.sv
// ok_stim_checker: exhaustive stimulus driver and 1-bit response checker
// for small combinational DUTs. It walks dut_in through every pattern,
// lets each one settle, compares dut_out with exp_out, counts mismatches
// and records the first failing vector.
module ok_stim_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  input  logic              exp_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [N_IN-1:0]   first_err_vec,
  output logic              first_err_valid
);

  // Settle counter is at least one bit wide so SETTLE=1 still elaborates.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LD = SW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [SW-1:0]    r_settle;
  logic [N_IN-1:0]  r_vec;
  logic [CNT_W-1:0] r_err;
  logic [N_IN-1:0]  r_fev;
  logic             r_fevv;
  logic             r_pass;

  logic             w_mismatch;
  logic             w_last;
  logic [CNT_W-1:0] w_err_nxt;

  assign w_mismatch = (dut_out != exp_out);
  assign w_last     = &r_vec;
  // Saturating increment: the counter sticks at all-ones.
  assign w_err_nxt  = (w_mismatch && !(&r_err)) ? r_err + 1'b1 : r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; start only matters in IDLE and is never queued.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_WAIT;
      S_WAIT:   if (r_settle == '0) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_WAIT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: vector stepping, settle timing, mismatch bookkeeping.
  // pass is resolved on the final SAMPLE edge so it is valid together
  // with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_vec    <= '0;
      r_err    <= '0;
      r_fev    <= '0;
      r_fevv   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec    <= '0;
            r_err    <= '0;
            r_fev    <= '0;
            r_fevv   <= 1'b0;
            r_pass   <= 1'b0;
            r_settle <= SET_LD;
          end
        end
        S_WAIT: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        S_SAMPLE: begin
          r_err <= w_err_nxt;
          if (w_mismatch && !r_fevv) begin
            r_fev  <= r_vec;
            r_fevv <= 1'b1;
          end
          if (w_last) begin
            r_pass <= (w_err_nxt == '0);
          end else begin
            r_vec    <= r_vec + 1'b1;
            r_settle <= SET_LD;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers; no input-to-output paths.
  assign dut_in          = r_vec;
  assign busy            = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign done            = (r_state == S_DONE);
  assign pass            = r_pass;
  assign err_cnt         = r_err;
  assign first_err_vec   = r_fev;
  assign first_err_valid = r_fevv;

endmodule

// File: tb/tb_ok_stim_checker.sv
// Bench for ok_stim_checker: three instances with different parameters,
// each driven by a stand-in DUT function plus a per-vector error mask.
// Expected behaviour is derived per cycle from vector/sample arithmetic.
module tb_ok_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st [3];
  logic [7:0] mask [3];

  int errs   = 0;
  int checks = 0;

  int NI [3] = '{3, 3, 1};
  int SS [3] = '{4, 1, 1};
  int CW [3] = '{8, 2, 8};

  // instance A: N_IN=3 SETTLE=4 CNT_W=8
  logic [2:0] din_a, fev_a;
  logic [7:0] err_a;
  logic       out_a, exp_a, busy_a, done_a, pass_a, fevv_a;
  // instance B: N_IN=3 SETTLE=1 CNT_W=2
  logic [2:0] din_b, fev_b;
  logic [1:0] err_b;
  logic       out_b, exp_b, busy_b, done_b, pass_b, fevv_b;
  // instance C: N_IN=1 SETTLE=1 CNT_W=8
  logic [0:0] din_c, fev_c;
  logic [7:0] err_c;
  logic       out_c, exp_c, busy_c, done_c, pass_c, fevv_c;

  // Stand-in for the ok netlist: x = (a & b) | ~c.
  assign out_a = (din_a[0] & din_a[1]) | ~din_a[2];
  assign out_b = (din_b[0] & din_b[1]) | ~din_b[2];
  assign out_c = ~din_c[0];
  assign exp_a = out_a ^ mask[0][din_a];
  assign exp_b = out_b ^ mask[1][din_b];
  assign exp_c = out_c ^ mask[2][din_c];

  ok_stim_checker #(.N_IN(3), .SETTLE(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .dut_in(din_a), .dut_out(out_a),
    .exp_out(exp_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_err_vec(fev_a), .first_err_valid(fevv_a));
  ok_stim_checker #(.N_IN(3), .SETTLE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .dut_in(din_b), .dut_out(out_b),
    .exp_out(exp_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_err_vec(fev_b), .first_err_valid(fevv_b));
  ok_stim_checker #(.N_IN(1), .SETTLE(1), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .dut_in(din_c), .dut_out(out_c),
    .exp_out(exp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_cnt(err_c), .first_err_vec(fev_c), .first_err_valid(fevv_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic observe(input int id,
                         output logic [31:0] vec, output logic [31:0] bsy,
                         output logic [31:0] dn, output logic [31:0] ps,
                         output logic [31:0] ec, output logic [31:0] fv,
                         output logic [31:0] fvv);
    case (id)
      0: begin vec = 32'(din_a); bsy = 32'(busy_a); dn = 32'(done_a); ps = 32'(pass_a);
               ec = 32'(err_a); fv = 32'(fev_a); fvv = 32'(fevv_a); end
      1: begin vec = 32'(din_b); bsy = 32'(busy_b); dn = 32'(done_b); ps = 32'(pass_b);
               ec = 32'(err_b); fv = 32'(fev_b); fvv = 32'(fevv_b); end
      default: begin vec = 32'(din_c); bsy = 32'(busy_c); dn = 32'(done_c); ps = 32'(pass_c);
               ec = 32'(err_c); fv = 32'(fev_c); fvv = 32'(fevv_c); end
    endcase
  endtask

  // One run: vector v is applied at edge k+v*(S+1) and sampled at
  // edge k+(v+1)*(S+1); done appears after edge k+2^N*(S+1).
  task automatic run(input int id, input logic [7:0] m, input bit hold);
    int nv, s, l, cmax, ns, ec, fe;
    logic [31:0] o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv;
    nv   = 1 << NI[id];
    s    = SS[id];
    l    = nv * (s + 1);
    cmax = (1 << CW[id]) - 1;
    mask[id] = m;
    @(posedge clk); #1 st[id] = 1'b1;
    @(posedge clk); #1;
    if (!hold) st[id] = 1'b0;
    for (int t = 0; t <= l + 1; t++) begin
      ns = t / (s + 1);
      if (ns > nv) ns = nv;
      ec = 0;
      fe = -1;
      for (int v = 0; v < ns; v++)
        if (m[v]) begin
          ec++;
          if (fe < 0) fe = v;
        end
      if (ec > cmax) ec = cmax;
      observe(id, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv);
      chk("dut_in",          o_vec,  (t < l) ? t / (s + 1) : nv - 1);
      chk("busy",            o_busy, 32'(t < l));
      chk("done",            o_done, 32'(t == l));
      chk("err_cnt",         o_err,  ec);
      chk("first_err_vec",   o_fev,  (fe < 0) ? 0 : fe);
      chk("first_err_valid", o_fevv, 32'(fe >= 0));
      chk("pass",            o_pass, 32'((t >= l) && (fe < 0)));
      if (t <= l) begin @(posedge clk); #1; end
    end
    if (hold) begin
      // start still high: a fresh run begins the cycle after IDLE returns
      @(posedge clk); #1;
      observe(id, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv);
      chk("rerun_busy", o_busy, 1);
      chk("rerun_vec",  o_vec,  0);
      chk("rerun_err",  o_err,  0);
      chk("rerun_pass", o_pass, 0);
      st[id] = 1'b0;
      for (int i = 0; i < 200; i++) begin
        observe(id, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv);
        if (o_done === 32'd1) break;
        @(posedge clk); #1;
      end
      chk("rerun_done", o_done, 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin st[i] = 1'b0; mask[i] = '0; end

    // reset state
    #12;
    observe(0, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv);
    chk("rst_vec", o_vec, 0);   chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0); chk("rst_pass", o_pass, 0);
    chk("rst_err", o_err, 0);   chk("rst_fevv", o_fevv, 0);
    rst_n = 1'b1;

    // perfect DUT, single injected mismatch at vector 5, random masks
    run(0, 8'h00, 1'b0);
    run(0, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) run(0, 8'($urandom), 1'b0);

    // start held high across a whole run
    run(0, 8'($urandom), 1'b1);

    // reset pulsed mid-run while dut_in == 3
    mask[0] = 8'h01;
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    for (int i = 0; i < 100 && din_a != 3'd3; i++) begin @(posedge clk); #1; end
    chk("reach_vec3", 32'(din_a), 3);
    #2 rst_n = 1'b0;
    #1;
    observe(0, o_vec, o_busy, o_done, o_pass, o_err, o_fev, o_fevv);
    chk("mid_rst_vec", o_vec, 0);   chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_err", o_err, 0);   chk("mid_rst_pass", o_pass, 0);
    chk("mid_rst_done", o_done, 0); chk("mid_rst_fevv", o_fevv, 0);
    @(posedge clk); #1;
    chk("mid_rst_nodone", 32'(done_a), 0);
    rst_n = 1'b1;
    run(0, 8'h00, 1'b0);

    // narrow counter saturates under constant mismatch; then random
    run(1, 8'hFF, 1'b0);
    run(1, 8'($urandom), 1'b0);

    // single-input, single-settle instance
    run(2, 8'h00, 1'b0);
    run(2, 8'h02, 1'b0);
    run(2, 8'h03, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
